// File: rtl/din_stream_tx.sv
// din_stream_tx
//   Buffers words written by a local producer in a DEPTH-entry circular
//   buffer and sends them out on a valid/busy stream interface, in write
//   order. A transfer happens on a rising edge with din_vld=1 and din_busy=0.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   wr_en     write request
//   wr_data   write data (DW bits)
//   wr_full   registered buffer-full flag; writes are dropped while high
//   din_vld   transmit data valid (registered FSM state only)
//   din_busy  receiver stall
//   din_data  transmit data (head of buffer; 0 while idle)
//   level     number of held entries, including the presented word
//   tx_count  16-bit wrapping transfer counter (only with the macro below)
//
// Optional feature macro: DIN_STREAM_TX_COUNT_EN adds the tx_count output.
module din_stream_tx #(
   parameter int DEPTH = 8,
   parameter int DW    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DW-1:0]          wr_data,
   output logic                   wr_full,
   output logic                   din_vld,
   input  logic                   din_busy,
   output logic [DW-1:0]          din_data,
   output logic [$clog2(DEPTH):0] level
`ifdef DIN_STREAM_TX_COUNT_EN
   ,
   output logic [15:0]            tx_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   level_next;
   logic          wr_acc;
   logic          xfer;
   logic [DW-1:0] mem [DEPTH];

   // wr_full is registered, so a write arriving in a full cycle is dropped
   // even if a transfer frees an entry on the same edge.
   assign wr_acc = wr_en & ~wr_full;
   assign xfer   = din_vld & ~din_busy;

   always_comb begin
      level_next = level;
      if (wr_acc && !xfer)
         level_next = level + LVL_ONE;
      else if (!wr_acc && xfer)
         level_next = level - LVL_ONE;
   end

   // Next-state and outputs. din_vld comes from the state register only,
   // so it has no combinational path from din_busy.
   always_comb begin
      state_next = state;
      din_vld    = 1'b0;
      din_data   = '0;
      case (state)
         IDLE: begin
            if (level_next != '0)
               state_next = SEND;
         end
         SEND: begin
            din_vld  = 1'b1;
            din_data = mem[rd_ptr];
            if (xfer && level_next == '0)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level   <= '0;
         wr_full <= 1'b0;
      end else begin
         state   <= state_next;
         level   <= level_next;
         wr_full <= (level_next == LVL_FULL);
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (xfer)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; pointers and level decide what is visible.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= wr_data;
   end

`ifdef DIN_STREAM_TX_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tx_count <= '0;
      else if (xfer)
         tx_count <= tx_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_din_stream_tx.sv
module tb_din_stream_tx;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_full;
   logic       din_vld;
   logic       din_busy;
   logic [7:0] din_data;
   logic [3:0] level;
`ifdef DIN_STREAM_TX_COUNT_EN
   logic [15:0] tx_count;
`endif

   int checks   = 0;
   int failures = 0;

   din_stream_tx #(.DEPTH(8), .DW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .wr_full  (wr_full),
      .din_vld  (din_vld),
      .din_busy (din_busy),
      .din_data (din_data),
      .level    (level)
`ifdef DIN_STREAM_TX_COUNT_EN
      ,
      .tx_count (tx_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       busy;
      logic       vld;
      logic [7:0] data;
      logic [3:0] level;
      logic       full;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [7:0] d, input logic b,
                      input logic v, input logic [7:0] ed, input logic [3:0] l,
                      input logic f);
      vec_t r;
      r.wr_en = w; r.wr_data = d; r.busy = b;
      r.vld = v; r.data = ed; r.level = l; r.full = f;
      vecs.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                            input logic [3:0] l, input logic f);
      check({tag, ".vld"}, 32'(din_vld), 32'(v));
      if (v)
         check({tag, ".data"}, 32'(din_data), 32'(d));
      check({tag, ".level"}, 32'(level), 32'(l));
      check({tag, ".full"}, 32'(wr_full), 32'(f));
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; din_busy = 1'b0;

      // single word round trip
      add(1, 8'h11, 0, 1, 8'h11, 1, 0);
      add(0, 8'h00, 0, 0, 8'h00, 0, 0);
      // fill under stall, ninth write dropped, then drain back to back
      for (int k = 1; k <= 8; k++)
         add(1, 8'(k), 1, 1, 8'h01, 4'(k), (k == 8));
      add(1, 8'h09, 1, 1, 8'h01, 8, 1);
      for (int k = 1; k <= 8; k++) begin
         if (k < 8) add(0, 8'h00, 0, 1, 8'(k + 1), 4'(8 - k), 0);
         else       add(0, 8'h00, 0, 0, 8'h00, 0, 0);
      end
      // full buffer: write and transfer on one edge, write is dropped
      for (int k = 1; k <= 8; k++)
         add(1, 8'(8'h20 + k), 1, 1, 8'h21, 4'(k), (k == 8));
      add(1, 8'hAA, 0, 1, 8'h22, 7, 0);
      for (int k = 1; k <= 7; k++) begin
         if (k < 7) add(0, 8'h00, 0, 1, 8'(8'h22 + k), 4'(7 - k), 0);
         else       add(0, 8'h00, 0, 0, 8'h00, 0, 0);
      end
      // level 3 with streaming write and transfer each cycle
      for (int k = 1; k <= 3; k++)
         add(1, 8'(8'h30 + k), 1, 1, 8'h31, 4'(k), 0);
      for (int k = 1; k <= 6; k++)
         add(1, 8'(8'h33 + k), 0, 1, 8'(8'h31 + k), 3, 0);
      add(0, 8'h00, 0, 1, 8'h38, 2, 0);
      add(0, 8'h00, 0, 1, 8'h39, 1, 0);
      add(0, 8'h00, 0, 0, 8'h00, 0, 0);
      // level 1: write and transfer together hand over to the new word
      add(1, 8'h41, 0, 1, 8'h41, 1, 0);
      add(1, 8'h42, 0, 1, 8'h42, 1, 0);
      add(0, 8'h00, 0, 0, 8'h00, 0, 0);

      // reset state
      step(); step();
      check("rst.vld", 32'(din_vld), 0);
      check("rst.data", 32'(din_data), 0);
      check("rst.level", 32'(level), 0);
      check("rst.full", 32'(wr_full), 0);
`ifdef DIN_STREAM_TX_COUNT_EN
      check("rst.tx_count", 32'(tx_count), 0);
`endif
      rst = 1'b0;

      foreach (vecs[i]) begin
         wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; din_busy = vecs[i].busy;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].data,
                   vecs[i].level, vecs[i].full);
      end

      // reset mid-burst discards buffered words
      for (int k = 1; k <= 5; k++) begin
         wr_en = 1'b1; wr_data = 8'(8'h50 + k); din_busy = 1'b1;
         step();
      end
      check_out("burst", 1, 8'h51, 5, 0);
      wr_en = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("mid_rst.vld", 32'(din_vld), 0);
      check("mid_rst.data", 32'(din_data), 0);
      check("mid_rst.level", 32'(level), 0);
      wr_en = 1'b1; wr_data = 8'h77; din_busy = 1'b0;
      step();
      check("rst_write.level", 32'(level), 0);
      check("rst_write.vld", 32'(din_vld), 0);
      rst = 1'b0; wr_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check_out($sformatf("post_rst%0d", k), 0, 8'h00, 0, 0);
      end
      wr_en = 1'b1; wr_data = 8'h55;
      step();
      check_out("new_write", 1, 8'h55, 1, 0);
      wr_en = 1'b0;
      step();
      check_out("new_drain", 0, 8'h00, 0, 0);

`ifdef DIN_STREAM_TX_COUNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt.start", 32'(tx_count), 0);
      wr_en = 1'b1; din_busy = 1'b0;
      for (int k = 0; k < 65537; k++) begin
         wr_data = 8'(k);
         step();
      end
      wr_en = 1'b0;
      step();
      check("cnt.wrap", 32'(tx_count), 32'h0001);
      check("cnt.level", 32'(level), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
